// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Upstream stage of control_circuit. Holds a 2**ADDR_WIDTH-entry program
//   memory loaded over a write port, steps a program counter and issues one
//   INSTRUCTION word per step, waiting for control_circuit's Done pulse
//   between issues. Drives NOP while idle or halted.
//
// Ports
//   clk          system clock, all state updates on posedge
//   reset        asynchronous active-high reset, returns block to IDLE
//   prog_we      program memory write strobe (accepted in IDLE/HALT only)
//   prog_addr    program memory write address
//   prog_data    program memory write data
//   prog_len     number of instructions to run, sampled on accepted start
//   start        single-cycle request to run from address 0
//   Done         from control_circuit, high in the final state of an instruction
//   INSTRUCTION  registered instruction word to control_circuit
//   pc           address of the current or last issued instruction
//   busy         high in ISSUE and WAIT
//   halted       high in HALT
//   write_err    one-cycle pulse after a prog_we arriving while busy
//   illegal_cnt  count of skipped 1xx opcodes, saturating, cleared on start
module instruction_sequencer #(
    parameter int              INSTR_WIDTH = 11,
    parameter int              ADDR_WIDTH  = 4,
    parameter logic [2:0]      NOP_OPCODE  = 3'b111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic [ADDR_WIDTH:0]    prog_len,
    input  logic                   start,
    input  logic                   Done,
    output logic [INSTR_WIDTH-1:0] INSTRUCTION,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   write_err,
    output logic [3:0]             illegal_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {NOP_OPCODE, {(INSTR_WIDTH - 3){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic                   write_err_q, write_err_d;
    logic [3:0]             illegal_q, illegal_d;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic                   busy_w;
    logic                   advance;
    logic [ADDR_WIDTH:0]    pc_inc;

    assign busy_w = (state_q == S_ISSUE) || (state_q == S_WAIT);
    // One extra bit so pc+1 can reach len==DEPTH without wrapping.
    assign pc_inc = {1'b0, pc_q} + 1'b1;

    // Program memory: not reset, writes dropped while a program runs.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_w) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        len_d       = len_q;
        illegal_d   = illegal_q;
        write_err_d = prog_we && busy_w;
        advance     = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    len_d     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    pc_d      = '0;
                    illegal_d = '0;
                    if (prog_len == '0) begin
                        state_d = S_HALT;
                        instr_d = NOP_WORD;
                    end else begin
                        state_d = S_ISSUE;
                        instr_d = mem_q[0];
                    end
                end
            end
            S_ISSUE: begin
                if (!instr_q[INSTR_WIDTH-1]) begin
                    state_d = S_WAIT;
                    instr_d = NOP_WORD;
                end else begin
                    // control_circuit never finishes a 1xx opcode, so skip it.
                    if (illegal_q != 4'hF) begin
                        illegal_d = illegal_q + 4'd1;
                    end
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (Done) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = NOP_WORD;
            end
        endcase

        // Shared by the WAIT/Done path and the illegal-skip path; issuing the
        // next word on the same edge gives back-to-back issue with no bubble.
        if (advance) begin
            if (pc_inc == len_q) begin
                state_d = S_HALT;
                instr_d = NOP_WORD;
            end else begin
                state_d = S_ISSUE;
                pc_d    = pc_inc[ADDR_WIDTH-1:0];
                instr_d = mem_q[pc_inc[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= NOP_WORD;
            pc_q        <= '0;
            len_q       <= '0;
            write_err_q <= 1'b0;
            illegal_q   <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            write_err_q <= write_err_d;
            illegal_q   <= illegal_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign pc          = pc_q;
    assign busy        = busy_w;
    assign halted      = (state_q == S_HALT);
    assign write_err   = write_err_q;
    assign illegal_cnt = illegal_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Upstream stage of control_circuit. Holds a small program memory, loaded over a write port.
- Steps a program counter and drives the 11-bit INSTRUCTION word into control_circuit.
- Issues each instruction for exactly one cycle, then waits for control_circuit's Done pulse before issuing the next.
- Stops at a programmed length and drives NOP (opcode 1xx) while idle so control_circuit stays in its initial state.

Parameters:
INSTR_WIDTH  11  instruction word width: opcode[10:8], operand[7:0]
ADDR_WIDTH   4   program memory address width; depth = 2**ADDR_WIDTH = 16
NOP_OPCODE   3'b111  opcode driven when no instruction is being issued

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high; returns block to IDLE
prog_we  in  1  program memory write strobe
prog_addr  in  ADDR_WIDTH  write address
prog_data  in  INSTR_WIDTH  write data
prog_len  in  ADDR_WIDTH+1  number of instructions to run, sampled on accepted start
start  in  1  single-cycle request to run from address 0
Done  in  1  from control_circuit; high in the final state of each instruction
INSTRUCTION  out  INSTR_WIDTH  registered instruction word to control_circuit
pc  out  ADDR_WIDTH  address of the current or last issued instruction
busy  out  1  high in ISSUE and WAIT
halted  out  1  high in HALT
write_err  out  1  one-cycle pulse when prog_we arrives while busy
illegal_cnt  out  4  count of skipped opcodes 1xx, saturates at 15, cleared on accepted start

Behaviour:
- Reset (asynchronous, immediate) sets the following:
  - state=IDLE, INSTRUCTION={NOP_OPCODE,8'h00}, pc=0, busy=0, halted=0, write_err=0, illegal_cnt=0, len register=0.
  - Memory contents are not reset.
- Memory: 16 x 11 register array, synchronous write.
  - Write is accepted only when state is IDLE or HALT.
  - A prog_we while busy is dropped, and write_err pulses high the next cycle.
- The len register latches min(prog_len, 16) on an accepted start.
- IDLE/HALT and start:
  - Start is accepted in IDLE or HALT only; start while busy is ignored.
  - If prog_len==0 -> HALT next cycle, pc=0, INSTRUCTION stays NOP.
  - Otherwise -> ISSUE; pc=0, INSTRUCTION=mem[0], illegal_cnt=0.
- ISSUE (exactly one cycle):
  - control_circuit samples INSTRUCTION on the following edge.
  - If INSTRUCTION[10]==0 (load/mov/add/sub) -> WAIT, and INSTRUCTION becomes NOP on that edge.
  - If INSTRUCTION[10]==1 (illegal; control_circuit would never Done), the instruction is skipped: illegal_cnt++ (saturating), then advance as below with no WAIT.
  - Done sampled in ISSUE is ignored.
- WAIT:
  - INSTRUCTION=NOP.
  - On the edge where Done==1: advance.
  - Without Done the block stays in WAIT indefinitely; there is no timeout.
- Advance:
  - If pc+1 == len -> HALT, INSTRUCTION=NOP, pc unchanged.
  - Otherwise pc <= pc+1, INSTRUCTION <= mem[pc+1], state ISSUE.
  - This gives back-to-back issue with no bubble: control_circuit re-enters its initial state on the same edge.
- Throughput in cycles from one ISSUE to the next ISSUE or HALT:
  - load/mov: 2
  - add/sub: 4
  - illegal: 1
- HALT: halted=1; held until an accepted start (restarts from address 0) or reset.
- pc never wraps; len <= 16 bounds pc at 15.
- Reset mid-program aborts immediately. control_circuit shares the same reset, so both return to initial/IDLE together.

Test Plan:
- Write mem[0]=11'b000_00100000 (load r1) and mem[1]=11'b001_01000100 (mov r2,r1); prog_len=2; pulse start at edge e0; bench uses real control_circuit.
  -> INSTRUCTION=mem[0] after e0; NOP after e1; mem[1] after e2; NOP after e3.
  -> halted=1 and pc=1 after e4.
- mem[0]=11'b010_00101000 (add r1,r2), len=1, start at e0.
  -> busy for 4 cycles; Rout/ALU sequence Add1, Add2, Add3 seen.
  -> halted after e4; INSTRUCTION=NOP from e1 onward.
- mem = {load r1, 11'b111_00000000, load r2}, len=3, start at e0.
  -> ISSUE at e0, e2, e3 (illegal word skipped without WAIT).
  -> halted after e5; illegal_cnt=1.
- Run the add program and assert reset while control_circuit is in Add2.
  -> all outputs at reset values immediately (INSTRUCTION=11'b111_00000000, busy=0).
  -> a later start reruns cleanly from pc=0.
- During busy, pulse prog_we with addr=0 and data=0.
  -> write_err=1 for exactly one cycle; mem[0] unchanged (verified by rerun).
  -> start during busy has no effect on pc.
- start with prog_len=0.
  -> halted=1 next cycle, pc=0, INSTRUCTION=NOP throughout.
  -> prog_len=17 with 16 loads runs 16 instructions and halts with pc=15.
